iram_download_loader: RTL and testbench

- Download sequencer for the user instruction RAM; runs while the SoC executes bootloader code.
- Consumes a framed byte stream from the UART RX path and packs bytes little-endian into 32-bit words.
- Writes the words sequentially into the user IRAM write port, checks length and checksum, and reports status on the system peripheral bus.
- Bootloader firmware arms it, polls status, then triggers the switch to user code.

---
 rtl/iram_download_loader_pkg.sv | 46 ++++
 rtl/iram_download_loader_if.sv | 22 ++
 rtl/iram_download_loader_word_packer.sv | 30 +++
 rtl/iram_download_loader.sv | 202 ++++++++++++++++++++
 tb/tb_iram_download_loader.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iram_download_loader_pkg.sv
// Shared types and constants for the IRAM download loader and its bus.
package iram_download_loader_pkg;

   localparam int unsigned SYS_ADDR_W = 8;
   localparam int unsigned SYS_DATA_W = 32;

   typedef struct packed {
      logic [SYS_ADDR_W-1:0] waddr;
      logic [SYS_ADDR_W-1:0] raddr;
      logic [SYS_DATA_W-1:0] wdata;
   } sys_peripheral_t;

   typedef struct packed {
      logic wen;
      logic ren;
   } sel_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SYNC = 3'd1,
      LEN0 = 3'd2,
      LEN1 = 3'd3,
      DATA = 3'd4,
      CSUM = 3'd5,
      DONE = 3'd6,
      ERR  = 3'd7
   } loader_state_e;

   typedef enum logic [2:0] {
      NONE      = 3'd0,
      BAD_LEN   = 3'd1,
      BAD_SUM   = 3'd2,
      TIMEOUT   = 3'd3,
      MODE_LOST = 3'd4
   } loader_err_e;

   localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

   localparam logic [SYS_ADDR_W-1:0] REG_CTRL  = SYS_ADDR_W'(0);
   localparam logic [SYS_ADDR_W-1:0] REG_COUNT = SYS_ADDR_W'(1);
   localparam logic [SYS_ADDR_W-1:0] REG_CSUM  = SYS_ADDR_W'(2);

   localparam int unsigned CTRL_ARM_BIT   = 0;
   localparam int unsigned CTRL_ABORT_BIT = 1;

endpackage

// File: rtl/iram_download_loader_if.sv
// UART RX byte stream plus system peripheral bus seen by the loader.
interface iram_download_loader_if;
   import iram_download_loader_pkg::*;

   logic [7:0]      rx_data;
   logic            rx_valid;
   logic            rx_ready;
   sys_peripheral_t sys_share;
   sel_t            sel;
   logic [31:0]     rdata;

   modport master (
      output rx_data, rx_valid, sys_share, sel,
      input  rx_ready, rdata
   );

   modport slave (
      input  rx_data, rx_valid, sys_share, sel,
      output rx_ready, rdata
   );

endinterface

// File: rtl/iram_download_loader_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_ready pulses the cycle after byte 3.
module loader_word_packer (
   input  logic        hb_clk,
   input  logic        rst_sync,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic [1:0]  lane,
   output logic        word_ready,
   output logic [31:0] word
);

   // Shifting in from the top leaves byte 0 in [7:0] once four bytes have arrived.
   always_ff @(posedge hb_clk or posedge rst_sync) begin
      if (rst_sync) begin
         lane       <= 2'd0;
         word_ready <= 1'b0;
         word       <= 32'd0;
      end else begin
         word_ready <= byte_en && !clear && (lane == 2'd3);
         if (clear) begin
            lane <= 2'd0;
         end else if (byte_en) begin
            lane <= 2'(lane + 2'd1);
            word <= {byte_data, word[31:8]};
         end
      end
   end

endmodule

// File: rtl/iram_download_loader.sv
// Framed UART download into user IRAM with length/checksum checking and bus status.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module iram_download_loader
   import iram_download_loader_pkg::*;
#(
   parameter int unsigned ADDR_W      = 12,
   parameter logic [23:0] TIMEOUT_CYC = 24'd12000000
) (
   input  logic                  hb_clk,
   input  logic                  rst_sync,
   iram_download_loader_if.slave bus,
   input  logic                  download_mode,
   output logic                  iram_we,
   output logic [ADDR_W-1:0]     iram_waddr,
   output logic [31:0]           iram_wdata
);

   localparam int unsigned LEN_W     = 16;
   localparam logic [16:0] MAX_WORDS = 17'(17'd1 << ADDR_W);

   loader_state_e state_q, state_d;
   loader_err_e   err_q, err_d;

   logic [7:0]       len_lo_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] words_rcvd_q;
   logic [LEN_W-1:0] words_written_q;
   logic [7:0]       csum_q;
   logic             rx_ready_q;
   logic [31:0]      rdata_q;

   logic             ctrl_wr_c, arm_c, abort_c, byte_ok_c, busy_c, done_c;
   logic             timeout_c, last_word_c;
   logic             restart_c, len_lo_ld_c, len_ld_c, data_byte_c;
   logic [LEN_W-1:0] len_c;
   logic [1:0]       pk_lane;
   logic             pk_word_ready;
   logic [31:0]      pk_word;

   assign ctrl_wr_c   = bus.sel.wen && (bus.sys_share.waddr == REG_CTRL);
   assign arm_c       = ctrl_wr_c && bus.sys_share.wdata[CTRL_ARM_BIT];
   assign abort_c     = ctrl_wr_c && bus.sys_share.wdata[CTRL_ABORT_BIT];
   // A same-cycle ARM/ABORT command takes precedence and drops the byte.
   assign byte_ok_c   = bus.rx_valid && rx_ready_q && !(arm_c || abort_c);
   assign busy_c      = state_q inside {SYNC, LEN0, LEN1, DATA, CSUM};
   assign done_c      = (state_q == DONE);
   assign len_c       = {bus.rx_data, len_lo_q};
   assign last_word_c = (LEN_W'(words_rcvd_q + LEN_W'(1)) == len_q);

`ifdef LOADER_TIMEOUT_EN
   logic [23:0] tmo_cnt_q;
   logic        timed_c;

   assign timed_c   = state_q inside {LEN0, LEN1, DATA, CSUM};
   assign timeout_c = timed_c && (tmo_cnt_q == TIMEOUT_CYC);

   always_ff @(posedge hb_clk or posedge rst_sync) begin
      if (rst_sync) begin
         tmo_cnt_q <= 24'd0;
      end else if (!timed_c || (bus.rx_valid && rx_ready_q)) begin
         tmo_cnt_q <= 24'd0;
      end else if (tmo_cnt_q != TIMEOUT_CYC) begin
         tmo_cnt_q <= 24'(tmo_cnt_q + 24'd1);
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
   assign timeout_c          = 1'b0;
`endif

   logic unused_wdata_bits;
   assign unused_wdata_bits = ^bus.sys_share.wdata[31:2];

   always_ff @(posedge hb_clk or posedge rst_sync) begin
      if (rst_sync) begin
         state_q <= IDLE;
         err_q   <= NONE;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   // Next state: bus commands, then mode loss / timeout, then frame parsing.
   always_comb begin
      state_d     = state_q;
      err_d       = err_q;
      restart_c   = 1'b0;
      len_lo_ld_c = 1'b0;
      len_ld_c    = 1'b0;
      data_byte_c = 1'b0;
      if (abort_c) begin
         state_d   = IDLE;
         err_d     = NONE;
         restart_c = 1'b1;
      end else if (arm_c && download_mode && !busy_c) begin
         state_d   = SYNC;
         err_d     = NONE;
         restart_c = 1'b1;
      end else if (busy_c && !download_mode) begin
         state_d = ERR;
         err_d   = MODE_LOST;
      end else if (timeout_c) begin
         state_d = ERR;
         err_d   = TIMEOUT;
      end else if (byte_ok_c) begin
         case (state_q)
            SYNC: begin
               if (bus.rx_data == LOADER_SYNC_BYTE) state_d = LEN0;
            end
            LEN0: begin
               len_lo_ld_c = 1'b1;
               state_d     = LEN1;
            end
            LEN1: begin
               len_ld_c = 1'b1;
               if ((len_c == '0) || ({1'b0, len_c} > MAX_WORDS)) begin
                  state_d = ERR;
                  err_d   = BAD_LEN;
               end else begin
                  state_d = DATA;
               end
            end
            DATA: begin
               data_byte_c = 1'b1;
               if ((pk_lane == 2'd3) && last_word_c) state_d = CSUM;
            end
            CSUM: begin
               if (bus.rx_data == csum_q) begin
                  state_d = DONE;
               end else begin
                  state_d = ERR;
                  err_d   = BAD_SUM;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge hb_clk or posedge rst_sync) begin
      if (rst_sync) begin
         rx_ready_q      <= 1'b0;
         len_lo_q        <= 8'd0;
         len_q           <= '0;
         words_rcvd_q    <= '0;
         words_written_q <= '0;
         csum_q          <= 8'd0;
      end else begin
         rx_ready_q <= state_d inside {SYNC, LEN0, LEN1, DATA, CSUM};
         if (restart_c) begin
            len_lo_q        <= 8'd0;
            len_q           <= '0;
            words_rcvd_q    <= '0;
            words_written_q <= '0;
            csum_q          <= 8'd0;
         end else begin
            if (len_lo_ld_c) len_lo_q <= bus.rx_data;
            if (len_ld_c)    len_q    <= len_c;
            if (data_byte_c) csum_q   <= 8'(csum_q + bus.rx_data);
            if (data_byte_c && (pk_lane == 2'd3))
               words_rcvd_q <= LEN_W'(words_rcvd_q + LEN_W'(1));
            if (pk_word_ready)
               words_written_q <= LEN_W'(words_written_q + LEN_W'(1));
         end
      end
   end

   loader_word_packer u_packer (
      .hb_clk     (hb_clk),
      .rst_sync   (rst_sync),
      .clear      (restart_c),
      .byte_en    (data_byte_c),
      .byte_data  (bus.rx_data),
      .lane       (pk_lane),
      .word_ready (pk_word_ready),
      .word       (pk_word)
   );

   assign iram_we    = pk_word_ready;
   assign iram_wdata = pk_word;
   assign iram_waddr = ADDR_W'(words_written_q);

   // Status readback, registered like the other system peripherals.
   always_ff @(posedge hb_clk or posedge rst_sync) begin
      if (rst_sync) begin
         rdata_q <= 32'd0;
      end else if (bus.sel.ren) begin
         case (bus.sys_share.raddr)
            REG_CTRL:  rdata_q <= {24'd0, 3'(err_q), 3'(state_q), busy_c, done_c};
            REG_COUNT: rdata_q <= {16'd0, words_written_q};
            REG_CSUM:  rdata_q <= {24'd0, csum_q};
            default:   rdata_q <= 32'd0;
         endcase
      end
   end

   assign bus.rx_ready = rx_ready_q;
   assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_iram_download_loader.sv
// Directed self-checking bench for iram_download_loader (ADDR_W=4, TIMEOUT_CYC=100).
module tb_iram_download_loader;
   import iram_download_loader_pkg::*;

   localparam int unsigned ADDR_W = 4;

   logic              hb_clk;
   logic              rst_sync;
   logic              download_mode;
   logic              iram_we;
   logic [ADDR_W-1:0] iram_waddr;
   logic [31:0]       iram_wdata;

   int tests;
   int errors;

   logic [31:0]       mem [16];
   int                wr_total;
   logic [ADDR_W-1:0] last_addr;

   iram_download_loader_if bus ();

   iram_download_loader #(
      .ADDR_W      (ADDR_W),
      .TIMEOUT_CYC (24'd100)
   ) dut (
      .hb_clk        (hb_clk),
      .rst_sync      (rst_sync),
      .bus           (bus),
      .download_mode (download_mode),
      .iram_we       (iram_we),
      .iram_waddr    (iram_waddr),
      .iram_wdata    (iram_wdata)
   );

   initial hb_clk = 1'b0;
   always #5 hb_clk = ~hb_clk;

   // IRAM model: records every write strobe
   initial wr_total = 0;
   always @(negedge hb_clk) begin
      if (iram_we === 1'b1) begin
         mem[iram_waddr] = iram_wdata;
         last_addr       = iram_waddr;
         wr_total        = wr_total + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      while (bus.rx_ready !== 1'b1 && n < 50) begin
         @(negedge hb_clk);
         n++;
      end
      if (bus.rx_ready !== 1'b1) begin
         tests++; errors++;
         $display("FAIL send_byte: rx_ready never rose for byte %h", b);
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge hb_clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
      bus.sel.wen         = 1'b1;
      bus.sys_share.waddr = addr;
      bus.sys_share.wdata = data;
      @(negedge hb_clk);
      bus.sel.wen = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
      bus.sel.ren         = 1'b1;
      bus.sys_share.raddr = addr;
      @(negedge hb_clk);
      bus.sel.ren = 1'b0;
      data = bus.rdata;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge hb_clk);
   endtask

   task automatic send_hdr(input logic [15:0] len);
      send_byte(8'hA5);
      send_byte(len[7:0]);
      send_byte(len[15:8]);
   endtask

   task automatic send_two_word_payload();
      logic [7:0] p [8];
      p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      for (int i = 0; i < 8; i++) send_byte(p[i]);
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      rst_sync = 1'b1;
      idle_cycles(3);
      rst_sync = 1'b0;
      idle_cycles(1);
      tests++; if (iram_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", iram_we); end
      tests++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b exp 0", bus.rx_ready); end
      tests++; if (bus.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.rdata); end
      bus_read(8'd0, rd);
      tests++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_status got %h exp 0", rd); end
   endtask

   task automatic test_good_frame();
      logic [31:0] rd;
      int          w0;
      w0 = wr_total;
      bus_write(8'd0, 32'h1);
      bus_read(8'd0, rd);
      tests++; if (rd !== 32'h06) begin errors++; $display("FAIL arm_status got %h exp 06", rd); end
      send_hdr(16'd2);
      send_two_word_payload();
      send_byte(8'h64);
      idle_cycles(2);
      tests++; if (wr_total - w0 !== 2) begin errors++; $display("FAIL good_writes got %0d exp 2", wr_total - w0); end
      tests++; if (mem[0] !== 32'h44332211) begin errors++; $display("FAIL good_word0 got %h exp 44332211", mem[0]); end
      tests++; if (mem[1] !== 32'h88776655) begin errors++; $display("FAIL good_word1 got %h exp 88776655", mem[1]); end
      bus_read(8'd0, rd);
      tests++; if (rd !== 32'h19) begin errors++; $display("FAIL good_status got %h exp 19", rd); end
      bus_read(8'd1, rd);
      tests++; if (rd !== 32'd2) begin errors++; $display("FAIL good_count got %h exp 2", rd); end
      bus_read(8'd2, rd);
      tests++; if (rd !== 32'h64) begin errors++; $display("FAIL good_csum got %h exp 64", rd); end
      bus_read(8'd9, rd);
      tests++; if (rd !== 32'd0) begin errors++; $display("FAIL unmapped_read got %h exp 0", rd); end
   endtask

   task automatic test_bad_sum();
      logic [31:0] rd;
      int          w0;
      mem[0] = 32'd0; mem[1] = 32'd0;
      w0 = wr_total;
      bus_write(8'd0, 32'h1);
      send_hdr(16'd2);
      send_two_word_payload();
      send_byte(8'h00);
      idle_cycles(2);
      tests++; if (wr_total - w0 !== 2) begin errors++; $display("FAIL badsum_writes got %0d exp 2", wr_total - w0); end
      tests++; if (mem[1] !== 32'h88776655) begin errors++; $display("FAIL badsum_word1 got %h exp 88776655", mem[1]); end
      bus_read(8'd0, rd);
      tests++; if (rd !== 32'h5C) begin errors++; $display("FAIL badsum_status got %h exp 5c", rd); end
   endtask

   task automatic test_bad_len_zero();
      logic [31:0] rd;
      int          w0;
      w0 = wr_total;
      bus_write(8'd0, 32'h1);
      send_hdr(16'd0);
      idle_cycles(2);
      tests++; if (wr_total !== w0) begin errors++; $display("FAIL len0_writes got %0d exp 0", wr_total - w0); end
      bus_read(8'd0, rd);
      tests++; if (rd !== 32'h3C) begin errors++; $display("FAIL len0_status got %h exp 3c", rd); end
      bus_write(8'd0, 32'h2);
      bus_read(8'd0, rd);
      tests++; if (rd !== 32'd0) begin errors++; $display("FAIL abort_status got %h exp 0", rd); end
      bus_read(8'd1, rd);
      tests++; if (rd !== 32'd0) begin errors++; $display("FAIL abort_count got %h exp 0", rd); end
   endtask

   task automatic test_len_bounds();
      logic [31:0] rd;
      int          w0;
      bus_write(8'd0, 32'h1);
      send_hdr(16'd17);
      bus_read(8'd0, rd);
      tests++; if (rd !== 32'h3C) begin errors++; $display("FAIL len17_status got %h exp 3c", rd); end
      w0 = wr_total;
      bus_write(8'd0, 32'h1);
      send_hdr(16'd16);
      for (int i = 0; i < 64; i++) send_byte(8'(i));
      send_byte(8'hE0);
      idle_cycles(2);
      tests++; if (wr_total - w0 !== 16) begin errors++; $display("FAIL len16_writes got %0d exp 16", wr_total - w0); end
      tests++; if (last_addr !== 4'd15) begin errors++; $display("FAIL len16_last_addr got %0d exp 15", last_addr); end
      tests++; if (mem[0] !== 32'h03020100) begin errors++; $display("FAIL len16_word0 got %h exp 03020100", mem[0]); end
      tests++; if (mem[15] !== 32'h3F3E3D3C) begin errors++; $display("FAIL len16_word15 got %h exp 3f3e3d3c", mem[15]); end
      bus_read(8'd0, rd);
      tests++; if (rd !== 32'h19) begin errors++; $display("FAIL len16_status got %h exp 19", rd); end
      bus_read(8'd1, rd);
      tests++; if (rd !== 32'd16) begin errors++; $display("FAIL len16_count got %h exp 10", rd); end
   endtask

   task automatic test_sync_skip();
      logic [31:0] rd;
      bus_write(8'd0, 32'h1);
      send_byte(8'h00);
      send_byte(8'hFF);
      send_hdr(16'd1);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      send_byte(8'h38);
      idle_cycles(2);
      tests++; if (mem[0] !== 32'hEFBEADDE) begin errors++; $display("FAIL skip_word0 got %h exp efbeadde", mem[0]); end
      tests++; if (last_addr !== 4'd0) begin errors++; $display("FAIL skip_addr got %0d exp 0", last_addr); end
      bus_read(8'd0, rd);
      tests++; if (rd !== 32'h19) begin errors++; $display("FAIL skip_status got %h exp 19", rd); end
   endtask

   task automatic test_arm_no_mode();
      logic [31:0] rd;
      bus_write(8'd0, 32'h2);
      download_mode = 1'b0;
      bus_write(8'd0, 32'h1);
      idle_cycles(1);
      bus_read(8'd0, rd);
      tests++; if (rd !== 32'd0) begin errors++; $display("FAIL nomode_status got %h exp 0", rd); end
      tests++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL nomode_rx_ready got %b exp 0", bus.rx_ready); end
      download_mode = 1'b1;
   endtask

   task automatic test_timeout();
      logic [31:0] rd;
      logic [31:0] exp;
      bus_write(8'd0, 32'h1);
      send_byte(8'hA5);
      send_byte(8'h05);
      idle_cycles(120);
`ifdef LOADER_TIMEOUT_EN
      exp = 32'h7C;
`else
      exp = 32'h0E;
`endif
      bus_read(8'd0, rd);
      tests++; if (rd !== exp) begin errors++; $display("FAIL timeout_status got %h exp %h", rd, exp); end
      bus_write(8'd0, 32'h2);
   endtask

   task automatic test_mode_lost();
      logic [31:0] rd;
      bus_write(8'd0, 32'h1);
      send_hdr(16'd1);
      send_byte(8'h11);
      download_mode = 1'b0;
      idle_cycles(1);
      bus_read(8'd0, rd);
      tests++; if (rd !== 32'h9C) begin errors++; $display("FAIL modelost_status got %h exp 9c", rd); end
      download_mode = 1'b1;
      bus_write(8'd0, 32'h2);
   endtask

   task automatic test_abort_wins();
      logic [31:0] rd;
      bus_write(8'd0, 32'h1);
      send_byte(8'hA5);
      bus.rx_valid        = 1'b1;
      bus.rx_data         = 8'h01;
      bus.sel.wen         = 1'b1;
      bus.sys_share.waddr = 8'd0;
      bus.sys_share.wdata = 32'h2;
      @(negedge hb_clk);
      bus.rx_valid = 1'b0;
      bus.sel.wen  = 1'b0;
      bus_read(8'd0, rd);
      tests++; if (rd !== 32'd0) begin errors++; $display("FAIL abortwin_status got %h exp 0", rd); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] rd;
      int          w0;
      bus_write(8'd0, 32'h1);
      send_hdr(16'd2);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      w0 = wr_total;
      rst_sync = 1'b1;
      idle_cycles(2);
      rst_sync = 1'b0;
      idle_cycles(3);
      tests++; if (wr_total !== w0) begin errors++; $display("FAIL rstmid_writes got %0d exp 0", wr_total - w0); end
      bus_read(8'd0, rd);
      tests++; if (rd !== 32'd0) begin errors++; $display("FAIL rstmid_status got %h exp 0", rd); end
   endtask

   initial begin
      tests               = 0;
      errors              = 0;
      rst_sync            = 1'b1;
      download_mode       = 1'b1;
      bus.rx_data         = 8'd0;
      bus.rx_valid        = 1'b0;
      bus.sel             = '0;
      bus.sys_share       = '0;
      @(negedge hb_clk);
      test_reset();
      test_good_frame();
      test_bad_sum();
      test_bad_len_zero();
      test_len_bounds();
      test_sync_skip();
      test_arm_no_mode();
      test_timeout();
      test_mode_lost();
      test_abort_wins();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
